// File: rtl/btb_update_queue.sv
// BTB update queue: filters resolved branches that need a BTB write and retires them in FIFO order.
// Optional build macro BTB_UPDQ_COALESCE_EN merges a new record into the youngest queued entry with the same index.
module btb_update_queue #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 20,
    parameter int PTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid,
    input  logic [31:0]           res_pc,
    input  logic                  res_taken,
    input  logic [31:0]           res_target,
    input  logic                  res_pred_hit,
    input  logic [31:0]           res_pred_target,
    output logic                  res_ready,
    input  logic                  upd_hold,
    output logic                  update_en,
    output logic [INDEX_BITS-1:0] update_index,
    output logic [TAG_BITS-1:0]   update_tag,
    output logic [31:0]           update_target,
    output logic [PTR_BITS:0]     count
);

    localparam int DEPTH = 1 << PTR_BITS;
    localparam logic [PTR_BITS:0] DEPTH_C = (PTR_BITS + 1)'(DEPTH);

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic [TAG_BITS-1:0]   tag;
        logic [31:0]           target;
    } entry_t;

    entry_t                slot_q [DEPTH];
    entry_t                slot_d [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]     count_q, count_d;

    entry_t                new_entry;
    logic                  need, accept, pop, push, merge, hit;
    logic [PTR_BITS-1:0]   hit_slot, scan_slot;
    logic                  unused_pc;

    // Only some PC bits form index/tag; the rest are intentionally ignored.
    assign unused_pc = ^res_pc;

    assign res_ready     = (count_q != DEPTH_C);
    assign update_en     = (count_q != '0) && !upd_hold;
    assign update_index  = slot_q[rd_ptr_q].index;
    assign update_tag    = slot_q[rd_ptr_q].tag;
    assign update_target = slot_q[rd_ptr_q].target;
    assign count         = count_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        new_entry = '{index:  res_pc[INDEX_BITS+1:2],
                      tag:    res_pc[31:32-TAG_BITS],
                      target: res_target};
        need      = res_taken && (!res_pred_hit || (res_pred_target != res_target));
        accept    = res_valid && res_ready;
        pop       = update_en;
        hit       = 1'b0;
        hit_slot  = '0;
        scan_slot = '0;
`ifdef BTB_UPDQ_COALESCE_EN
        // Scan oldest to youngest so the last match wins; a head that pops this cycle is skipped.
        for (int k = 0; k < DEPTH; k++) begin
            scan_slot = rd_ptr_q + PTR_BITS'(k);
            if (((PTR_BITS + 1)'(k) < count_q) && !(k == 0 && pop) &&
                (slot_q[scan_slot].index == new_entry.index)) begin
                hit      = 1'b1;
                hit_slot = scan_slot;
            end
        end
`endif
        push  = accept && need && !hit;
        merge = accept && need && hit;

        slot_d = slot_q;
        if (merge) begin
            slot_d[hit_slot].tag    = new_entry.tag;
            slot_d[hit_slot].target = new_entry.target;
        end
        if (push) begin
            slot_d[wr_ptr_q] = new_entry;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (PTR_BITS + 1)'(push) - (PTR_BITS + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: slots are cleared on reset because update_* expose the head slot and must read zero.
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
